spi_reg_slave: RTL and testbench

- SPI mode-0 responder. An external controller (MCU/FPGA) uses it to read and write the CPLD's internal 7-bit-addressed register space over SCK/CS_n/MOSI/MISO.
- Complements the on-chip SD-card SPI master: here the CPLD is the target, not the initiator.
- All SPI pins are oversampled in the clk28 domain. Register-side accesses are single-cycle strobes.

---
 rtl/spi_reg_slave_pkg.sv | 21 ++
 rtl/spi_reg_slave_if.sv | 30 +++
 rtl/spi_sync_edge.sv | 27 ++
 rtl/spi_reg_slave.sv | 150 +++++++++++++++
 tb/tb_spi_reg_slave.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_slave_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_reg_slave_pkg;

  localparam int unsigned REG_AW = 7;
  localparam int unsigned REG_DW = 8;

  // Byte shifted out on MISO while the command byte is clocked in.
  localparam logic [7:0] SPI_SLAVE_ID = 8'h5A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_slave_state_t;

  // Register address auto-increment, wraps 7F -> 00.
  function automatic logic [REG_AW-1:0] addr_inc(input logic [REG_AW-1:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pins plus register-side bus of the SPI register responder.
interface spi_reg_slave_if;
  import spi_reg_slave_pkg::*;

  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [REG_AW-1:0] reg_addr;
  logic [REG_DW-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [REG_DW-1:0] reg_rdata;
  logic              busy;
  logic              abort;

  // Responder side (the CPLD block).
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy, abort
  );

  // Controller plus register file side.
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy, abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  logic                   level;

  assign level = sync_ff[SYNC_STAGES-1];

  // Deliberately not reset: the chain keeps tracking the pin during reset, so a pin
  // already low at reset release produces no spurious edge.
  always_ff @(posedge clk) begin
    sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    hist    <= level;
  end

  assign rise = level & ~hist;
  assign fall = ~level & hist;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder giving an external controller access to a 7-bit register space.
// Byte 0 is the command {dir, addr[6:0]} (dir 1 = write); following bytes are data
// with address auto-increment. All SPI pins are oversampled in the clk28 domain.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_BYTE     = SPI_SLAVE_ID
) (
  input  logic           clk28,
  input  logic           rst,
  spi_reg_slave_if.slave bus
);

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   mosi_sync;

  spi_slave_state_t  state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_in;
  logic [7:0]        shift_out;
  logic [7:0]        tx_next;
  logic              dir;
  logic              rd_pend;
  logic              oe;
  logic [REG_AW-1:0] addr;
  logic [REG_DW-1:0] wdata;
  logic              wr;
  logic              rd;
  logic              abort_p;
  logic [7:0]        byte_in;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sck (
    .clk (clk28),
    .din (bus.spi_sck),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk (clk28),
    .din (bus.spi_cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // MOSI needs only the level, delayed to match the SCK edge detector.
  always_ff @(posedge clk28) begin
    mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign mosi_sync = mosi_ff[SYNC_STAGES-1];
  assign byte_in   = {shift_in[6:0], mosi_sync};

  // Transaction FSM, shift registers and register-side strobes.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'hFF;
      tx_next   <= 8'h00;
      dir       <= 1'b0;
      rd_pend   <= 1'b0;
      oe        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      abort_p   <= 1'b0;
    end else begin
      wr      <= 1'b0;
      rd      <= 1'b0;
      abort_p <= 1'b0;

      // Follow-ups of an issued strobe complete even if CS is released meanwhile.
      if (rd) tx_next <= bus.reg_rdata;
      if (wr) addr <= addr_inc(addr);
      if (rd_pend) begin
        rd      <= 1'b1;
        rd_pend <= 1'b0;
      end

      if (cs_rise) begin
        state     <= IDLE;
        oe        <= 1'b0;
        bit_cnt   <= 3'd0;
        abort_p   <= (bit_cnt != 3'd0);
        shift_out <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state     <= CMD;
              shift_out <= ID_BYTE;
              bit_cnt   <= 3'd0;
              oe        <= 1'b1;
            end
          end
          CMD, DATA: begin
            if (sck_rise) begin
              shift_in <= byte_in;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  addr  <= byte_in[6:0];
                  dir   <= byte_in[7];
                  state <= DATA;
                  if (byte_in[7]) tx_next <= 8'h00;
                  else            rd      <= 1'b1;
                end else if (dir) begin
                  wdata <= byte_in;
                  wr    <= 1'b1;
                end else begin
                  // Advance first, then prefetch the next byte one cycle later.
                  addr    <= addr_inc(addr);
                  rd_pend <= 1'b1;
                end
              end
            end else if (sck_fall) begin
              // bit_cnt wraps to 0 after a full byte: that fall starts the next byte.
              if (bit_cnt == 3'd0) shift_out <= tx_next;
              else                 shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.spi_miso    = shift_out[7];
  assign bus.spi_miso_oe = oe;
  assign bus.reg_addr    = addr;
  assign bus.reg_wdata   = wdata;
  assign bus.reg_wr      = wr;
  assign bus.reg_rd      = rd;
  assign bus.busy        = (state != IDLE);
  assign bus.abort       = abort_p;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: write/read bursts, wrap, abort, reset mid-transfer.
module tb_spi_reg_slave;

  localparam int HALF = 6;  // SCK half period in clk28 cycles

  logic clk28;
  logic rst;

  int passes = 0;
  int total  = 0;

  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [6:0] rd_addr_q[$];
  int         abort_cnt = 0;
  logic       both_seen = 1'b0;

  logic [7:0] rx;

  spi_reg_slave_if bus ();

  spi_reg_slave dut (
    .clk28(clk28),
    .rst  (rst),
    .bus  (bus)
  );

  // Register file model: read data is the inverted address.
  assign bus.reg_rdata = ~{1'b0, bus.reg_addr};

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk28) begin
    if (!rst) begin
      if (bus.reg_wr) begin
        wr_addr_q.push_back(bus.reg_addr);
        wr_data_q.push_back(bus.reg_wdata);
      end
      if (bus.reg_rd) rd_addr_q.push_back(bus.reg_addr);
      if (bus.abort) abort_cnt <= abort_cnt + 1;
      if (bus.reg_wr && bus.reg_rd) both_seen <= 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Mode 0: MISO sampled just before each rising SCK edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = tx[7-i];
      wait_clk(HALF);
      rxb = {rxb[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      wait_clk(HALF);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    bus.spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    rst          = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;

    // Reset
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("rst_miso", 32'(bus.spi_miso), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wr", 32'(bus.reg_wr), 32'd0);
    check("rst_rd", 32'(bus.reg_rd), 32'd0);
    check("rst_addr", 32'(bus.reg_addr), 32'h00);
    check("rst_wdata", 32'(bus.reg_wdata), 32'h00);

    // Write burst: addr 5 <- 3C, addr 6 <- 7E
    clear_log();
    cs_start();
    check("wr_oe", 32'(bus.spi_miso_oe), 32'd1);
    check("wr_busy", 32'(bus.busy), 32'd1);
    spi_xfer(8'h85, 8, rx);
    check("wr_miso0", 32'(rx), 32'h5A);
    spi_xfer(8'h3C, 8, rx);
    check("wr_miso1", 32'(rx), 32'h00);
    spi_xfer(8'h7E, 8, rx);
    check("wr_miso2", 32'(rx), 32'h00);
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(1);
    check("wr_busy_hold", 32'(bus.busy), 32'd1);
    wait_clk(3);
    check("wr_busy_fall", 32'(bus.busy), 32'd0);
    check("wr_oe_off", 32'(bus.spi_miso_oe), 32'd0);
    wait_clk(4);
    check("wr_count", 32'(wr_addr_q.size()), 32'd2);
    check("wr_addr0", 32'(wr_addr_q[0]), 32'h05);
    check("wr_data0", 32'(wr_data_q[0]), 32'h3C);
    check("wr_addr1", 32'(wr_addr_q[1]), 32'h06);
    check("wr_data1", 32'(wr_data_q[1]), 32'h7E);
    check("wr_no_rd", 32'(rd_addr_q.size()), 32'd0);
    check("wr_no_abort", 32'(abort_cnt), 32'd0);

    // Read burst from 0x10 with prefetch
    clear_log();
    cs_start();
    spi_xfer(8'h10, 8, rx);
    check("rd_miso0", 32'(rx), 32'h5A);
    spi_xfer(8'hFF, 8, rx);
    check("rd_miso1", 32'(rx), 32'hEF);
    spi_xfer(8'hFF, 8, rx);
    check("rd_miso2", 32'(rx), 32'hEE);
    cs_end();
    check("rd_count", 32'(rd_addr_q.size()), 32'd3);
    check("rd_addr0", 32'(rd_addr_q[0]), 32'h10);
    check("rd_addr1", 32'(rd_addr_q[1]), 32'h11);
    check("rd_addr2", 32'(rd_addr_q[2]), 32'h12);
    check("rd_no_wr", 32'(wr_addr_q.size()), 32'd0);

    // Address wrap 7F -> 00
    clear_log();
    cs_start();
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    cs_end();
    check("wrap_count", 32'(wr_addr_q.size()), 32'd2);
    check("wrap_addr0", 32'(wr_addr_q[0]), 32'h7F);
    check("wrap_data0", 32'(wr_data_q[0]), 32'h11);
    check("wrap_addr1", 32'(wr_addr_q[1]), 32'h00);
    check("wrap_data1", 32'(wr_data_q[1]), 32'h22);

    // Abort on a partial data byte
    clear_log();
    cs_start();
    spi_xfer(8'h81, 8, rx);
    spi_xfer(8'hA0, 4, rx);
    cs_end();
    check("abort_cnt", 32'(abort_cnt), 32'd1);
    check("abort_no_wr", 32'(wr_addr_q.size()), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    cs_start();
    spi_xfer(8'h81, 8, rx);
    spi_xfer(8'h55, 8, rx);
    cs_end();
    check("abort_next_count", 32'(wr_addr_q.size()), 32'd1);
    check("abort_next_addr", 32'(wr_addr_q[0]), 32'h01);
    check("abort_next_data", 32'(wr_data_q[0]), 32'h55);
    check("abort_cnt_stable", 32'(abort_cnt), 32'd1);

    // Reset during a data byte with CS held low
    clear_log();
    cs_start();
    spi_xfer(8'h81, 8, rx);
    spi_xfer(8'hC0, 3, rx);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    spi_xfer(8'h00, 8, rx);
    wait_clk(4);
    check("mid_no_wr", 32'(wr_addr_q.size()), 32'd0);
    check("mid_no_rd", 32'(rd_addr_q.size()), 32'd0);
    check("mid_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_miso", 32'(bus.spi_miso), 32'd1);
    cs_end();
    check("mid_no_abort", 32'(abort_cnt), 32'd1);
    cs_start();
    spi_xfer(8'h82, 8, rx);
    check("mid_id", 32'(rx), 32'h5A);
    spi_xfer(8'hA5, 8, rx);
    cs_end();
    check("mid_after_count", 32'(wr_addr_q.size()), 32'd1);
    check("mid_after_addr", 32'(wr_addr_q[0]), 32'h02);
    check("mid_after_data", 32'(wr_data_q[0]), 32'hA5);

    check("strobe_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
